ccff_chain_driver: RTL and testbench
====================================

// Module: ccff_chain_driver
// PURPOSE
//  Drives one configuration-chain segment (ccff_head in, ccff_tail out) of a
//  routing tile (cbx/cby/sb). Serializes host words into ccff_head, MSB first,
//  and gates the chain shift. Simultaneously reads back the bits leaving ccff_tail
//  (the previous chain contents) as words. Asserts cfg_done once CHAIN_LEN bits are in.
// PARAMETERS
//  CHAIN_LEN  16  total chain bits in the driven segment (>=1)
//  DATA_W     8   host/readback word width (>=2)
//  (localparams: NWORDS=ceil(CHAIN_LEN/DATA_W), CNT_W=clog2(CHAIN_LEN+1))
// PORTS
//  prog_clk       in   1       the only clock; everything is on its rising edge
//  prog_reset     in   1       synchronous, active-low reset
//  start          in   1       pulse: begin a load (ignored outside IDLE/DONE)
//  s_valid        in   1       host write word valid
//  s_data         in   DATA_W  host write word
//  s_ready        out  1       word accepted when s_valid&s_ready
//  ccff_head      out  1       serial bit into chain head
//  ccff_tail      in   1       serial bit out of chain tail
//  ccff_shift_en  out  1       chain clock-enable; chain shifts at edge when 1
//  busy           out  1       state==LOAD
//  cfg_done       out  1       chain fully loaded; held until next start/reset
//  rb_valid       out  1       readback word valid
//  rb_data        out  DATA_W  readback word; first bit out of tail in MSB
//  rb_ready       in   1       readback consumer ready
// BEHAVIOUR
//  Reset (prog_reset=0 at edge): state=IDLE; every output 0; counters and hold cleared.
//  - Reset mid-LOAD aborts. Chain contents are undefined; cfg_done stays 0.
//  FSM IDLE->LOAD on start. LOAD->DONE after last shift + final rb push.
//  - DONE->LOAD on start. start while LOAD ignored.
//  - Entering LOAD clears cfg_done, bit_cnt, word_cnt, rb assembly.
//  Hold register: one word + bit index.
//  - s_ready = LOAD & ~hold_valid & word_cnt<NWORDS; it never depends on s_valid/rb_ready.
//  - Words are accepted only in LOAD. A cycle with s_valid=1 in IDLE/DONE has no effect.
//  Shift condition: shift = hold_valid & ~(rb_valid & rb_cnt==DATA_W-1).
//  - ccff_shift_en = shift. ccff_head = hold[DATA_W-1-bit_idx] (combinational from regs).
//  - ccff_head=0 when not shifting.
//  - On shift: ccff_tail is sampled into rb assembly (MSB first); bit_idx++; bit_cnt++.
//  - Hold empties after its last bit. Min cost per full word: 1 accept + DATA_W shifts.
//  Last word: if CHAIN_LEN%DATA_W=r!=0, only its r MSBs are shifted; the low bits are
//   discarded. The final rb word is left-aligned with zero fill.
//  Readback: word complete -> rb_data/rb_valid=1 next edge. It stays stable until rb_ready.
//  - Shifting stalls rather than overwrite an unconsumed rb word.
//  - The partial final rb word is pushed the cycle after the last shift, or once
//   rb_valid clears.
//  Completion: after the final rb push, state=DONE and cfg_done=1 next edge.
//  - busy=0 and s_ready=0 in DONE. rb_valid may still be 1 pending consumption.
//  bit_cnt never exceeds CHAIN_LEN; no shift occurs once bit_cnt==CHAIN_LEN.
// TESTING (bench: 16-bit chain model preloaded 0xF00F, tail=its MSB)
//  1 Load CHAIN_LEN=16, DATA_W=8, rb_ready=1; send 0xA5 then 0x3C.
//    -> ccff_head seq 1010_0101_0011_1100 on shift_en cycles; rb 0xF0 then 0x0F.
//    -> model=0xA53C; cfg_done=1.
//  2 Throughput: s_valid held 1 -> 16 shift_en cycles within 18 cycles of first s_ready.
//    -> cfg_done within 2 cycles after last shift.
//  3 Backpressure: rb_ready=0 -> rb_valid=1 (0xF0) after 8 shifts, then 7 more shifts.
//    -> shift_en stuck 0. One rb_ready pulse resumes; 16 shifts total, no bit lost.
//  4 Partial word: CHAIN_LEN=12, words 0xA5, 0xBF -> 12 shifts, last four 1,0,1,1.
//    -> final rb_data low nibble 0. No third s_ready.
//  5 Reset mid-LOAD after 5 shifts -> all outputs 0 next cycle.
//    -> a new start performs a full 16-bit load.
//  6 start during LOAD, and s_valid in IDLE -> no effect; bit/word counts unchanged.

Source files
------------

// File: rtl/ccff_chain_driver.sv
// Configuration-chain segment driver: serializes host words MSB-first into
// ccff_head and gates the chain shift. Bits leaving ccff_tail (the previous
// chain contents) are collected back into words. cfg_done is raised after the
// whole chain is loaded and the final readback word has been pushed.
module ccff_chain_driver #(
  parameter int CHAIN_LEN = 16,
  parameter int DATA_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              cfg_done,
  output logic              rb_valid,
  output logic [DATA_W-1:0] rb_data,
  input  logic              rb_ready
);

  localparam int NWORDS = (CHAIN_LEN + DATA_W - 1) / DATA_W;
  localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int WC_W   = $clog2(NWORDS + 1);
  localparam int IDX_W  = $clog2(DATA_W);
  localparam int REM    = CHAIN_LEN % DATA_W;
  // Left-align a short final readback word; zeros fill the low bits.
  localparam int PAD    = (REM == 0) ? 0 : DATA_W - REM;

  localparam logic [CNT_W-1:0] CL       = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CL_M1    = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WC_W-1:0]  NW       = WC_W'(NWORDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] hold;
  logic              hold_valid;
  logic [IDX_W-1:0]  bit_idx;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WC_W-1:0]   word_cnt;
  logic [DATA_W-1:0] rb_asm;
  logic [IDX_W-1:0]  rb_cnt;
  logic              fin;      // final readback word has been pushed
  logic              shift;
  logic [DATA_W-1:0] hold_sh;

  // Shift stalls when the next tail bit would complete a word while the
  // previous readback word is still unconsumed.
  assign shift         = hold_valid & ~(rb_valid & (rb_cnt == IDX_LAST));
  assign hold_sh       = hold << bit_idx;
  assign ccff_head     = shift & hold_sh[DATA_W-1];
  assign ccff_shift_en = shift;
  assign busy          = (state == LOAD);
  assign s_ready       = (state == LOAD) & ~hold_valid & (word_cnt < NW);

  // Load FSM, hold register, readback assembly and completion.
  always_ff @(posedge prog_clk) begin
    if (!prog_reset) begin
      state      <= IDLE;
      hold       <= '0;
      hold_valid <= 1'b0;
      bit_idx    <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      rb_asm     <= '0;
      rb_cnt     <= '0;
      rb_valid   <= 1'b0;
      rb_data    <= '0;
      cfg_done   <= 1'b0;
      fin        <= 1'b0;
    end else begin
      if (rb_valid && rb_ready) rb_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= LOAD;
            cfg_done   <= 1'b0;
            hold_valid <= 1'b0;
            bit_idx    <= '0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            rb_asm     <= '0;
            rb_cnt     <= '0;
            fin        <= 1'b0;
          end
        end
        LOAD: begin
          if (s_valid && s_ready) begin
            hold       <= s_data;
            hold_valid <= 1'b1;
            bit_idx    <= '0;
            word_cnt   <= word_cnt + WC_W'(1);
          end
          if (shift) begin
            bit_idx <= bit_idx + IDX_W'(1);
            bit_cnt <= bit_cnt + CNT_W'(1);
            rb_asm  <= {rb_asm[DATA_W-2:0], ccff_tail};
            // Hold empties after its last bit, or the last chain bit of a short word.
            if (bit_idx == IDX_LAST || bit_cnt == CL_M1) hold_valid <= 1'b0;
            if (rb_cnt == IDX_LAST) begin
              rb_data  <= {rb_asm[DATA_W-2:0], ccff_tail};
              rb_valid <= 1'b1;
              rb_cnt   <= '0;
              if (bit_cnt == CL_M1) fin <= 1'b1;
            end else begin
              rb_cnt <= rb_cnt + IDX_W'(1);
            end
          end
          // Partial final readback word, once the output slot is free.
          if (bit_cnt == CL && !fin && (!rb_valid || rb_ready)) begin
            rb_data  <= rb_asm << PAD;
            rb_valid <= 1'b1;
            rb_cnt   <= '0;
            fin      <= 1'b1;
          end
          if (fin) begin
            state    <= DONE;
            cfg_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_chain_driver.sv
// Bench for ccff_chain_driver: a 16-bit and a 12-bit instance, each driving a
// behavioural shift-register chain. Directed table, random loads against a
// stream-level reference, and hand sequences for throughput, backpressure,
// start during load, mid-load reset and s_valid while idle.
module tb_ccff_chain_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       prog_reset, start, sel, s_valid, rb_ready;
  logic [7:0] s_data;
  logic       start16, start12;
  assign start16 = start & ~sel;
  assign start12 = start & sel;

  logic       s_ready16, head16, shift16, busy16, done16, rbv16;
  logic [7:0] rbd16;
  logic       s_ready12, head12, shift12, busy12, done12, rbv12;
  logic [7:0] rbd12;

  logic [15:0] chain16 = 16'hF00F;
  logic [11:0] chain12 = 12'hA5C;

  always @(posedge clk) if (shift16) chain16 <= {chain16[14:0], head16};
  always @(posedge clk) if (shift12) chain12 <= {chain12[10:0], head12};

  ccff_chain_driver #(.CHAIN_LEN(16), .DATA_W(8)) dut16 (
    .prog_clk(clk), .prog_reset(prog_reset), .start(start16),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready16),
    .ccff_head(head16), .ccff_tail(chain16[15]), .ccff_shift_en(shift16),
    .busy(busy16), .cfg_done(done16), .rb_valid(rbv16), .rb_data(rbd16),
    .rb_ready(rb_ready));

  ccff_chain_driver #(.CHAIN_LEN(12), .DATA_W(8)) dut12 (
    .prog_clk(clk), .prog_reset(prog_reset), .start(start12),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready12),
    .ccff_head(head12), .ccff_tail(chain12[11]), .ccff_shift_en(shift12),
    .busy(busy12), .cfg_done(done12), .rb_valid(rbv12), .rb_data(rbd12),
    .rb_ready(rb_ready));

  logic        cur_s_ready, cur_head, cur_shift, cur_busy, cur_done, cur_rbv;
  logic [7:0]  cur_rbd;
  logic [15:0] cur_chain;
  logic [13:0] cur_outs;
  assign cur_s_ready = sel ? s_ready12 : s_ready16;
  assign cur_head    = sel ? head12    : head16;
  assign cur_shift   = sel ? shift12   : shift16;
  assign cur_busy    = sel ? busy12    : busy16;
  assign cur_done    = sel ? done12    : done16;
  assign cur_rbv     = sel ? rbv12     : rbv16;
  assign cur_rbd     = sel ? rbd12     : rbd16;
  assign cur_chain   = sel ? {4'h0, chain12} : chain16;
  assign cur_outs    = {cur_busy, cur_done, cur_rbv, cur_s_ready, cur_shift, cur_head, cur_rbd};

  typedef struct {
    bit          sl;
    logic [7:0]  w0, w1;
    logic [15:0] e_hp;
    logic [7:0]  e_rb0, e_rb1;
  } vec_t;
  vec_t tbl [4];

  int          passed = 0, total = 0;
  logic [15:0] hp, old_ch;
  int          nsh, idx, nacc, nrb;
  logic [7:0]  wv [2];
  logic [7:0]  rbs [4];
  bit          tmo;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // One cycle of host/consumer activity, sampled at the negedge.
  task automatic tick(input bit sv, input bit rr);
    if (cur_shift) begin hp = {hp[14:0], cur_head}; nsh++; end
    s_valid = sv;
    s_data  = (idx < 2) ? wv[idx] : 8'h00;
    if (s_valid && cur_s_ready) begin idx++; nacc++; end
    rb_ready = rr;
    if (cur_rbv && rr) begin
      if (nrb < 4) rbs[nrb] = cur_rbd;
      nrb++;
    end
    @(negedge clk);
  endtask

  task automatic begin_load(input bit sl, input logic [7:0] w0, input logic [7:0] w1);
    sel = sl; wv[0] = w0; wv[1] = w1;
    hp = '0; nsh = 0; idx = 0; nacc = 0; nrb = 0;
    for (int i = 0; i < 4; i++) rbs[i] = 8'h00;
    @(negedge clk);
    old_ch = cur_chain;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_load();
    tmo = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if (cur_done && !cur_rbv) begin tmo = 1'b0; break; end
      tick(1'b1, 1'b1);
    end
    s_valid = 1'b0;
  endtask

  task automatic run_load(input bit sl, input logic [7:0] w0, input logic [7:0] w1,
                          input bit rv, input bit rr);
    begin_load(sl, w0, w1);
    tmo = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (cur_done && !cur_rbv) begin tmo = 1'b0; break; end
      tick(rv ? 1'($urandom_range(0, 1)) : 1'b1,
           (cur_done || !rr) ? 1'b1 : 1'($urandom_range(0, 1)));
    end
    s_valid = 1'b0;
  endtask

  // Stream-level reference: head bits are the word stream truncated to the
  // chain length; readback is the old chain, MSB first, left-aligned.
  task automatic ref_load(input bit sl, input logic [7:0] w0, input logic [7:0] w1,
                          input logic [15:0] old, output logic [15:0] e_hp,
                          output logic [7:0] e0, output logic [7:0] e1);
    int sh;
    logic [15:0] oal;
    sh   = sl ? 4 : 0;
    e_hp = {w0, w1} >> sh;
    oal  = old << sh;
    e0   = oal[15:8];
    e1   = oal[7:0];
  endtask

  task automatic check_res(input string tg, input bit sl, input logic [15:0] e_hp,
                           input logic [7:0] e0, input logic [7:0] e1);
    chk({tg, ".timeout"}, 32'(tmo), 32'd0);
    chk({tg, ".nshift"},  32'(nsh), sl ? 32'd12 : 32'd16);
    chk({tg, ".head"},    32'(hp), 32'(e_hp));
    chk({tg, ".nrb"},     32'(nrb), 32'd2);
    chk({tg, ".rb0"},     32'(rbs[0]), 32'(e0));
    chk({tg, ".rb1"},     32'(rbs[1]), 32'(e1));
    chk({tg, ".naccept"}, 32'(nacc), 32'd2);
    chk({tg, ".chain"},   32'(cur_chain), 32'(e_hp));
    chk({tg, ".done"},    32'({cur_done, cur_busy, cur_s_ready}), 32'b100);
  endtask

  initial begin
    logic [15:0] e_hp;
    logic [7:0]  e0, e1, w0, w1;
    bit          sl, bad;

    prog_reset = 1'b0; start = 1'b0; sel = 1'b0;
    s_valid = 1'b0; s_data = 8'h00; rb_ready = 1'b0;
    tbl[0] = '{1'b0, 8'hA5, 8'h3C, 16'hA53C, 8'hF0, 8'h0F};
    tbl[1] = '{1'b0, 8'h12, 8'h34, 16'h1234, 8'hA5, 8'h3C};
    tbl[2] = '{1'b1, 8'hA5, 8'hBF, 16'h0A5B, 8'hA5, 8'hC0};
    tbl[3] = '{1'b1, 8'h00, 8'hFF, 16'h000F, 8'hA5, 8'hB0};

    repeat (3) @(negedge clk);
    chk("reset16", 32'(cur_outs), 32'd0);
    sel = 1'b1; #1;
    chk("reset12", 32'(cur_outs), 32'd0);
    prog_reset = 1'b1;

    // Directed table.
    for (int i = 0; i < 4; i++) begin
      run_load(tbl[i].sl, tbl[i].w0, tbl[i].w1, 1'b0, 1'b0);
      check_res($sformatf("tbl%0d", i), tbl[i].sl, tbl[i].e_hp, tbl[i].e_rb0, tbl[i].e_rb1);
    end

    // Random loads with random host gaps and consumer backpressure.
    for (int i = 0; i < 16; i++) begin
      sl = 1'($urandom_range(0, 1));
      w0 = 8'($urandom); w1 = 8'($urandom);
      run_load(sl, w0, w1, 1'b1, 1'b1);
      ref_load(sl, w0, w1, old_ch, e_hp, e0, e1);
      check_res($sformatf("rnd%0d", i), sl, e_hp, e0, e1);
    end

    // Throughput: 16 shifts within 18 cycles of the first s_ready.
    begin_load(1'b0, 8'h81, 8'h7E);
    chk("tput.first_ready", 32'(cur_s_ready), 32'd1);
    repeat (18) tick(1'b1, 1'b1);
    chk("tput.nshift18", 32'(nsh), 32'd16);
    for (int k = 0; k < 2 && !cur_done; k++) tick(1'b1, 1'b1);
    chk("tput.done_lat", 32'(cur_done), 32'd1);
    finish_load();
    ref_load(1'b0, 8'h81, 8'h7E, old_ch, e_hp, e0, e1);
    check_res("tput", 1'b0, e_hp, e0, e1);

    // Backpressure: stall after 15 shifts, one rb_ready pulse resumes.
    begin_load(1'b0, 8'h96, 8'h69);
    repeat (40) tick(1'b1, 1'b0);
    chk("bp.nshift15", 32'(nsh), 32'd15);
    chk("bp.rbv",      32'(cur_rbv), 32'd1);
    chk("bp.rbd0",     32'(cur_rbd), 32'(old_ch[15:8]));
    chk("bp.stall",    32'(cur_shift), 32'd0);
    tick(1'b1, 1'b1);
    repeat (20) tick(1'b1, 1'b0);
    chk("bp.nshift16", 32'(nsh), 32'd16);
    chk("bp.done",     32'(cur_done), 32'd1);
    chk("bp.rbv1",     32'(cur_rbv), 32'd1);
    chk("bp.rbd1",     32'(cur_rbd), 32'(old_ch[7:0]));
    finish_load();
    ref_load(1'b0, 8'h96, 8'h69, old_ch, e_hp, e0, e1);
    check_res("bp", 1'b0, e_hp, e0, e1);

    // start pulse in the middle of a load has no effect.
    begin_load(1'b0, 8'h5A, 8'hC3);
    repeat (4) tick(1'b1, 1'b1);
    start = 1'b1;
    tick(1'b1, 1'b1);
    start = 1'b0;
    finish_load();
    ref_load(1'b0, 8'h5A, 8'hC3, old_ch, e_hp, e0, e1);
    check_res("midstart", 1'b0, e_hp, e0, e1);

    // Reset after 5 shifts; then s_valid while idle; then a full load.
    begin_load(1'b0, 8'hC3, 8'h3C);
    for (int n = 0; n < 40 && nsh < 5; n++) tick(1'b1, 1'b1);
    chk("rstmid.nshift", 32'(nsh), 32'd5);
    prog_reset = 1'b0;
    @(negedge clk);
    chk("rstmid.outs", 32'(cur_outs), 32'd0);
    prog_reset = 1'b1;
    s_valid = 1'b1; s_data = 8'hFF; bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (cur_s_ready || cur_busy || cur_shift || cur_done) bad = 1'b1;
    end
    chk("idle_svalid", 32'(bad), 32'd0);
    s_valid = 1'b0;
    run_load(1'b0, 8'hE7, 8'h18, 1'b0, 1'b0);
    ref_load(1'b0, 8'hE7, 8'h18, old_ch, e_hp, e0, e1);
    check_res("after_rst", 1'b0, e_hp, e0, e1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
